prm_edge_mask_engine: RTL and testbench

PRM_EDGE_MASK_ENGINE -- requirements
Module: prm_edge_mask_engine

---
 rtl/prm_edge_mask_engine_if.sv | 57 +++++
 rtl/prm_edge_mask_engine.sv | 207 ++++++++++++++++++++
 tb/tb_prm_edge_mask_engine.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prm_edge_mask_engine_if.sv
// ---------------------------------------------------------------------------
// prm_edge_mask_engine_if
//
// Bundles the configuration, query and result channels of
// prm_edge_mask_engine into one interface.
//
// Parameters:
//   IN_W  - query vector width in bits (bit 0 = joint bit A)
//   DEPTH - cube-table entries (power of two)
//
// Signals:
//   cfg_we / cfg_addr / cfg_care / cfg_val - cube-table write port
//   cfg_cnt  - active cube count, sampled when a query is accepted
//   cfg_err  - sticky flag for a write dropped outside IDLE
//   in_valid / in_ready / in_vec           - query channel
//   out_valid / out_ready / out_mask /
//   out_idx / out_cyc                      - result channel
//
// Modports:
//   master - the agent that issues queries and table writes
//   slave  - the engine itself
// ---------------------------------------------------------------------------
interface prm_edge_mask_engine_if #(
    parameter int IN_W  = 15,
    parameter int DEPTH = 256
);
    localparam int AW = $clog2(DEPTH);

    logic            cfg_we;
    logic [AW-1:0]   cfg_addr;
    logic [IN_W-1:0] cfg_care;
    logic [IN_W-1:0] cfg_val;
    logic [AW:0]     cfg_cnt;
    logic            cfg_err;

    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] in_vec;

    logic            out_valid;
    logic            out_ready;
    logic            out_mask;
    logic [AW-1:0]   out_idx;
    logic [15:0]     out_cyc;

    modport master (
        output cfg_we, cfg_addr, cfg_care, cfg_val, cfg_cnt,
        output in_valid, in_vec, out_ready,
        input  cfg_err, in_ready, out_valid, out_mask, out_idx, out_cyc
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_care, cfg_val, cfg_cnt,
        input  in_valid, in_vec, out_ready,
        output cfg_err, in_ready, out_valid, out_mask, out_idx, out_cyc
    );
endinterface

// File: rtl/prm_edge_mask_engine.sv
// ---------------------------------------------------------------------------
// prm_edge_mask_engine
//
// Classifies a configuration vector against a table of cubes (care/value
// pairs). A cube matches when every bit it cares about equals its value;
// a cube with care == 0 therefore matches everything. The table is scanned
// LANES entries per cycle and the lowest-index match over the active cube
// count is reported as out_idx with out_mask = 1.
//
// Parameters:
//   IN_W  - query vector width (default 15)
//   DEPTH - cube-table entries, power of two (default 256)
//   LANES - cubes compared per cycle, DEPTH divisible by LANES (default 4)
//
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - prm_edge_mask_engine_if.slave (cfg, query and result channels)
//
// Build option:
//   PRM_EMASK_EARLY_EXIT_EN - when defined, the scan stops at the end of
//   the first group containing a match. When undefined, every query scans
//   all ceil(count/LANES) groups so latency depends only on the count.
//   out_mask and out_idx are the same in both builds.
// ---------------------------------------------------------------------------
module prm_edge_mask_engine #(
    parameter int IN_W  = 15,
    parameter int DEPTH = 256,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    prm_edge_mask_engine_if.slave  bus
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   LANES_W = (AW+1)'(LANES);

`ifdef PRM_EMASK_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IN_W-1:0] vec_q,   vec_d;
    logic [AW:0]     cnt_q,   cnt_d;
    // Group counter held as the first entry index of the group (g*LANES),
    // which is what the lane address math needs directly.
    logic [AW-1:0]   base_q,  base_d;
    logic            hit_q,   hit_d;
    logic [AW-1:0]   idx_q,   idx_d;
    logic [15:0]     cyc_q,   cyc_d;
    logic            err_q,   err_d;

    logic [IN_W-1:0] care_mem [DEPTH];
    logic [IN_W-1:0] val_mem  [DEPTH];

    logic [LANES-1:0] lane_match;
    logic             lane_hit;
    logic [AW-1:0]    lane_idx;
    logic             last_grp;
    logic             scan_exit;
    logic             accept;

    assign accept = (state_q == S_IDLE) && bus.in_valid;

    // ---------------------------------------------------------------
    // Cube table. Writes are honoured only in IDLE, so a write in the
    // accept cycle lands before the first SCAN read of that query.
    // ---------------------------------------------------------------
    // NOTE: the table has no reset on purpose; clearing it would force a
    // reset fan-out to every entry and the contents are defined by writes.
    always_ff @(posedge clk) begin
        if (bus.cfg_we && (state_q == S_IDLE)) begin
            care_mem[bus.cfg_addr] <= bus.cfg_care;
            val_mem[bus.cfg_addr]  <= bus.cfg_val;
        end
    end

    // ---------------------------------------------------------------
    // Lane comparators for the current group, plus a lowest-lane pick.
    // ---------------------------------------------------------------
    // NOTE: every variable written here gets a default first, otherwise
    // the paths that skip an assignment would infer latches.
    always_comb begin
        lane_match = '0;
        lane_hit   = 1'b0;
        lane_idx   = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_match[l] =
                (((vec_q ^ val_mem[base_q + AW'(l)]) & care_mem[base_q + AW'(l)]) == '0) &&
                ({1'b0, base_q + AW'(l)} < cnt_q);
        end
        for (int l = 0; l < LANES; l++) begin
            if (lane_match[l] && !lane_hit) begin
                lane_hit = 1'b1;
                lane_idx = base_q + AW'(l);
            end
        end
    end

    // The current group is the last one when it reaches or passes the count.
    assign last_grp  = (({1'b0, base_q} + LANES_W) >= cnt_q);
    assign scan_exit = last_grp || (EARLY_EXIT && lane_hit);

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            base_q  <= '0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
            cyc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
            cyc_q   <= cyc_d;
            err_q   <= err_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = (bus.cfg_cnt == '0) ? S_DONE : S_SCAN;
            S_SCAN: if (scan_exit) state_d = S_DONE;
            S_DONE: if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath next values
    // ---------------------------------------------------------------
    always_comb begin
        vec_d  = vec_q;
        cnt_d  = cnt_q;
        base_d = base_q;
        hit_d  = hit_q;
        idx_d  = idx_q;
        cyc_d  = cyc_q;
        err_d  = err_q;

        // Writes outside IDLE are dropped; the flag stays set until reset.
        if (bus.cfg_we && (state_q != S_IDLE)) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    vec_d  = bus.in_vec;
                    cnt_d  = bus.cfg_cnt;
                    base_d = '0;
                    hit_d  = 1'b0;
                    idx_d  = '0;
                    cyc_d  = '0;
                end
            end
            S_SCAN: begin
                cyc_d = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
                // Groups are visited in ascending order, so the first group
                // with a hit holds the lowest matching index.
                if (!hit_q && lane_hit) begin
                    hit_d = 1'b1;
                    idx_d = lane_idx;
                end
                base_d = scan_exit ? '0 : base_q + AW'(LANES);
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);
        bus.out_mask  = hit_q;
        bus.out_idx   = idx_q;
        bus.out_cyc   = cyc_q;
        bus.cfg_err   = err_q;
    end

endmodule

// File: tb/tb_prm_edge_mask_engine.sv
// ---------------------------------------------------------------------------
// tb_prm_edge_mask_engine
//
// Self-checking bench for prm_edge_mask_engine (default parameters).
// Expected results come from a reference model that keeps its own copy of
// the cube table and evaluates a query directly from the matching rule:
// first index below the count whose cared bits equal the value, and a
// cycle count of ceil(count/LANES) groups (or up to the matching group when
// PRM_EMASK_EARLY_EXIT_EN is defined). Inputs are driven and outputs
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_prm_edge_mask_engine;

    localparam int IN_W  = 15;
    localparam int DEPTH = 256;
    localparam int LANES = 4;
    localparam int AW    = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prm_edge_mask_engine_if #(.IN_W(IN_W), .DEPTH(DEPTH)) bus ();

    prm_edge_mask_engine #(.IN_W(IN_W), .DEPTH(DEPTH), .LANES(LANES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [IN_W-1:0] m_care [DEPTH];
    logic [IN_W-1:0] m_val  [DEPTH];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: scan the model table in index order, first match wins.
    task automatic model_query(input logic [IN_W-1:0] vec, input int cnt,
                               output bit mask, output int idx, output int cyc);
        int groups;
        mask = 1'b0;
        idx  = 0;
        for (int k = 0; k < cnt; k++) begin
            if (!mask && (((vec ^ m_val[k]) & m_care[k]) == '0)) begin
                mask = 1'b1;
                idx  = k;
            end
        end
        groups = (cnt + LANES - 1) / LANES;
`ifdef PRM_EMASK_EARLY_EXIT_EN
        cyc = mask ? (idx / LANES + 1) : groups;
`else
        cyc = groups;
`endif
    endtask

    task automatic cfg_write(input int addr, input logic [IN_W-1:0] care, input logic [IN_W-1:0] val);
        @(negedge clk);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = AW'(addr);
        bus.cfg_care = care;
        bus.cfg_val  = val;
        m_care[addr] = care;
        m_val[addr]  = val;
        @(negedge clk);
        bus.cfg_we   = 1'b0;
    endtask

    // Wait (bounded) for out_valid; lat counts falling edges since the
    // accept cycle, so a query with c SCAN cycles shows out_valid at c+1.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 600) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, ":valid_dropped"}, bus.out_valid, 0);
        check({tag, ":ready_after"},   bus.in_ready,  1);
    endtask

    // One query, optionally with a table write in the accept cycle and a
    // number of stall cycles with out_ready low.
    task automatic run_query(input string tag, input logic [IN_W-1:0] vec, input int cnt,
                             input int stall, input bit sim_we, input int waddr,
                             input logic [IN_W-1:0] wcare, input logic [IN_W-1:0] wval);
        bit em;
        int ei, ec, lat;
        @(negedge clk);
        check({tag, ":in_ready"}, bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_vec   = vec;
        bus.cfg_cnt  = (AW+1)'(cnt);
        if (sim_we) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_addr = AW'(waddr);
            bus.cfg_care = wcare;
            bus.cfg_val  = wval;
            m_care[waddr] = wcare;
            m_val[waddr]  = wval;
        end
        model_query(vec, cnt, em, ei, ec);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.cfg_we   = 1'b0;
        wait_result(lat);
        check({tag, ":latency"}, lat, ec + 1);
        check({tag, ":mask"},    bus.out_mask, em);
        check({tag, ":idx"},     bus.out_idx,  ei);
        check({tag, ":cyc"},     bus.out_cyc,  ec);
        check({tag, ":no_ready_in_done"}, bus.in_ready, 0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check({tag, ":hold_valid"}, bus.out_valid, 1);
            check({tag, ":hold_mask"},  bus.out_mask,  em);
            check({tag, ":hold_idx"},   bus.out_idx,   ei);
            check({tag, ":hold_cyc"},   bus.out_cyc,   ec);
        end
        handshake(tag);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit em;
        int ei, ec, lat;
        bit pulse;

        rst           = 1'b1;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_care  = '0;
        bus.cfg_val   = '0;
        bus.cfg_cnt   = '0;
        bus.in_valid  = 1'b0;
        bus.in_vec    = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst:in_ready",  bus.in_ready,  1);
        check("rst:out_valid", bus.out_valid, 0);
        check("rst:out_mask",  bus.out_mask,  0);
        check("rst:out_idx",   bus.out_idx,   0);
        check("rst:out_cyc",   bus.out_cyc,   0);
        check("rst:cfg_err",   bus.cfg_err,   0);

        // Single exact cube, count 1
        cfg_write(0, 15'h7FFF, 15'h4200);
        run_query("single", 15'h4200, 1, 0, 1'b0, 0, '0, '0);

        // Count 9: cubes 0-7 require bit1=1 (never met), cube 8 tests bit0
        for (int k = 0; k < 8; k++) cfg_write(k, 15'h0002, 15'h0002);
        cfg_write(8, 15'h0001, 15'h0001);
        run_query("cnt9_hit",  15'h0001, 9, 0, 1'b0, 0, '0, '0);
        run_query("cnt9_miss", 15'h0000, 9, 0, 1'b0, 0, '0, '0);

        // Count 16 with matches at 5 and 13
        for (int k = 0; k < 16; k++) cfg_write(k, 15'h7FFF, 15'h1234);
        cfg_write(5,  15'h7FFF, 15'h0ABC);
        cfg_write(13, 15'h7FFF, 15'h0ABC);
        run_query("two_hits", 15'h0ABC, 16, 0, 1'b0, 0, '0, '0);

        // Count 0 with out_ready held low for 5 cycles
        run_query("cnt0_stall", 15'h0ABC, 0, 5, 1'b0, 0, '0, '0);

        // Write in the accept cycle is visible to that query (care=0 is universal)
        run_query("accept_we", 15'h7777, 4, 0, 1'b1, 0, 15'h0000, 15'h0000);
        cfg_write(0, 15'h7FFF, 15'h1234);

        // Write during SCAN is dropped and sets the sticky error flag
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_vec   = 15'h0ABC;
        bus.cfg_cnt  = 9'd16;
        model_query(15'h0ABC, 16, em, ei, ec);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 8'd5;
        bus.cfg_care = 15'h7FFF;
        bus.cfg_val  = 15'h0000;
        @(negedge clk);
        bus.cfg_we   = 1'b0;
        check("scan_we:cfg_err", bus.cfg_err, 1);
        wait_result(lat);
        check("scan_we:idx",  bus.out_idx,  ei);
        check("scan_we:mask", bus.out_mask, em);
        handshake("scan_we");
        run_query("after_drop", 15'h0ABC, 16, 0, 1'b0, 0, '0, '0);
        check("err_sticky", bus.cfg_err, 1);

        // Reset during SCAN abandons the query
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_vec   = 15'h0ABC;
        bus.cfg_cnt  = 9'd16;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("scan_rst:in_ready", bus.in_ready, 1);
        check("scan_rst:cfg_err",  bus.cfg_err,  0);
        pulse = bus.out_valid;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            pulse = pulse | bus.out_valid;
        end
        check("scan_rst:no_valid", pulse, 0);

        // Randomised queries against the model
        for (int k = 0; k < DEPTH; k++)
            cfg_write(k, 15'($urandom & $urandom & $urandom), 15'($urandom));
        for (int it = 0; it < 40; it++) begin
            int cnt, n_wr;
            logic [IN_W-1:0] vec, care;
            n_wr = $urandom_range(0, 6);
            for (int w = 0; w < n_wr; w++) begin
                care = ($urandom_range(0, 7) == 0) ? 15'h0 : 15'($urandom & $urandom & $urandom);
                cfg_write($urandom_range(0, 39), care, 15'($urandom));
            end
            cnt = ($urandom_range(0, 7) == 0) ? DEPTH : $urandom_range(0, 40);
            vec = 15'($urandom);
            if ($urandom_range(0, 2) == 0) vec = m_val[$urandom_range(0, 39)];
            run_query($sformatf("rnd%0d", it), vec, cnt, $urandom_range(0, 2),
                      1'($urandom_range(0, 3) == 0), $urandom_range(0, 39),
                      15'($urandom & $urandom), 15'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
